// File: rtl/add_sub_pkg.sv
// ---------------------------------------------------------------------------
// add_sub_pkg
//   Shared types and defaults for the pipelined adder/subtractor.
//   - add_sub_mode_e  : per-transaction operation select (ADD / SUB)
//   - add_sub_flags_t : status flags delivered alongside each result
//   - make_flags      : folds final-slice carries and result into flags
// ---------------------------------------------------------------------------
package add_sub_pkg;

   localparam int unsigned DEFAULT_WIDTH = 16;
   localparam int unsigned DEFAULT_CHUNK = 4;

   typedef enum logic {
      ADD = 1'b0,
      SUB = 1'b1
   } add_sub_mode_e;

   typedef struct packed {
      logic co;
      logic v;
      logic n;
      logic z;
   } add_sub_flags_t;

   // Signed overflow is present when the carry into the MSB disagrees with
   // the carry out of it.
   function automatic add_sub_flags_t make_flags(
      input logic carry_out,
      input logic carry_into_msb,
      input logic result_msb,
      input logic result_zero
   );
      add_sub_flags_t f;
      f.co = carry_out;
      f.v  = carry_into_msb ^ carry_out;
      f.n  = result_msb;
      f.z  = result_zero;
      return f;
   endfunction

endpackage

// File: rtl/add_sub_chunk.sv
// ---------------------------------------------------------------------------
// add_sub_chunk
//   Combinational CHUNK-bit ripple slice of the adder/subtractor.
//   Ports:
//     a, b   : operand slices
//     m      : ADD (b used as-is) or SUB (b inverted)
//     cin    : carry into the slice LSB
//     s      : slice sum
//     cout   : carry out of the slice MSB
//     c_msb  : carry into the slice MSB (signed-overflow detection)
// ---------------------------------------------------------------------------
module add_sub_chunk
   import add_sub_pkg::*;
#(
   parameter int unsigned CHUNK = DEFAULT_CHUNK
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  add_sub_mode_e    m,
   input  logic             cin,
   output logic [CHUNK-1:0] s,
   output logic             cout,
   output logic             c_msb
);

   logic [CHUNK-1:0] b_eff_s;
   logic [CHUNK:0]   total_s;

   // Conditionally invert b and ripple-add the slice with its carry-in.
   always_comb begin
      b_eff_s = (m == SUB) ? ~b : b;
      total_s = {1'b0, a} + {1'b0, b_eff_s} + {{CHUNK{1'b0}}, cin};
      s       = total_s[CHUNK-1:0];
      cout    = total_s[CHUNK];
      // Each sum bit is a ^ b ^ carry-in, so the carry into the MSB can be
      // recovered from the MSB sum bit without a second adder.
      c_msb   = s[CHUNK-1] ^ a[CHUNK-1] ^ b_eff_s[CHUNK-1];
   end

endmodule

// File: rtl/pipelined_add_sub.sv
// ---------------------------------------------------------------------------
// pipelined_add_sub
//   WIDTH-bit two's-complement adder/subtractor resolved CHUNK bits per
//   pipeline stage, with valid/ready handshakes on both sides.
//   Ports:
//     clk, rst_n          : clock, asynchronous active-low reset
//     in_valid / in_ready : upstream handshake for A, B, M
//     A, B, M             : operands and mode (0 = A+B, 1 = A-B)
//     out_valid/out_ready : downstream handshake for the result
//     Sum, Co, V, N, Z    : registered result and status flags
//   Latency is WIDTH/CHUNK cycles; one transaction per cycle without stalls.
//   A stall freezes every stage at once so bubbles are never collapsed.
// ---------------------------------------------------------------------------
module pipelined_add_sub
   import add_sub_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH,
   parameter int unsigned CHUNK = DEFAULT_CHUNK
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             M,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Sum,
   output logic             Co,
   output logic             V,
   output logic             N,
   output logic             Z
);

   localparam int unsigned STAGES = WIDTH / CHUNK;

   if ((CHUNK < 1) || (WIDTH < CHUNK) || ((WIDTH % CHUNK) != 0)) begin : g_param_check
      $error("pipelined_add_sub: WIDTH must be a non-zero multiple of CHUNK");
   end

   // Inputs to each stage: index 0 is fed from the ports, index k+1 from
   // the pipeline register behind stage k.
   logic [STAGES-1:0] stg_vld_s;
   logic [STAGES-1:0] stg_cin_s;
   add_sub_mode_e     stg_m_s   [STAGES];
   logic [WIDTH-1:0]  stg_a_s   [STAGES];
   logic [WIDTH-1:0]  stg_b_s   [STAGES];
   logic [WIDTH-1:0]  stg_sum_s [STAGES];

   // Combinational result of the final stage.
   logic             res_vld_s;
   logic [WIDTH-1:0] res_sum_s;
   logic             res_co_s;
   logic             res_cmsb_s;

   logic             stall_s;
   logic             out_valid_d, out_valid_q;
   logic [WIDTH-1:0] sum_d, sum_q;
   add_sub_flags_t   flags_d, flags_q;

   assign stall_s  = out_valid_q && !out_ready;
   assign in_ready = !stall_s;

   assign stg_vld_s[0] = in_valid && in_ready;
   assign stg_cin_s[0] = M;
   assign stg_m_s[0]   = add_sub_mode_e'(M);
   assign stg_a_s[0]   = A;
   assign stg_b_s[0]   = B;
   assign stg_sum_s[0] = {WIDTH{1'b0}};

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic [CHUNK-1:0] s_s;
      logic             cout_s;
      logic             c_msb_s;
      logic [WIDTH-1:0] sum_next_s;

      add_sub_chunk #(
         .CHUNK (CHUNK)
      ) u_chunk (
         .a     (stg_a_s[k][CHUNK-1:0]),
         .b     (stg_b_s[k][CHUNK-1:0]),
         .m     (stg_m_s[k]),
         .cin   (stg_cin_s[k]),
         .s     (s_s),
         .cout  (cout_s),
         .c_msb (c_msb_s)
      );

      // Finished slices shift down as new ones enter at the top, so after
      // the last stage every slice sits in its final bit position.
      assign sum_next_s = (stg_sum_s[k] >> CHUNK) | (WIDTH'(s_s) << (WIDTH - CHUNK));

      if (k < STAGES - 1) begin : g_pipe
         logic             vld_d, vld_q;
         logic             cin_d, cin_q;
         add_sub_mode_e    m_d, m_q;
         logic [WIDTH-1:0] a_d, a_q;
         logic [WIDTH-1:0] b_d, b_q;
         logic [WIDTH-1:0] sum_d_s, sum_q_s;
         logic             unused_cmsb_s;

         assign unused_cmsb_s = c_msb_s;

         // Next state of this stage: advance unless the output is stalled;
         // operands shift so the next slice is always in the low chunk.
         always_comb begin
            vld_d   = vld_q;
            cin_d   = cin_q;
            m_d     = m_q;
            a_d     = a_q;
            b_d     = b_q;
            sum_d_s = sum_q_s;
            if (!stall_s) begin
               vld_d = stg_vld_s[k];
               if (stg_vld_s[k]) begin
                  cin_d   = cout_s;
                  m_d     = stg_m_s[k];
                  a_d     = stg_a_s[k] >> CHUNK;
                  b_d     = stg_b_s[k] >> CHUNK;
                  sum_d_s = sum_next_s;
               end else begin
                  sum_d_s = sum_q_s;
               end
            end else begin
               vld_d = vld_q;
            end
         end

         // Stage register with its valid bit.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               vld_q   <= 1'b0;
               cin_q   <= 1'b0;
               m_q     <= ADD;
               a_q     <= {WIDTH{1'b0}};
               b_q     <= {WIDTH{1'b0}};
               sum_q_s <= {WIDTH{1'b0}};
            end else begin
               vld_q   <= vld_d;
               cin_q   <= cin_d;
               m_q     <= m_d;
               a_q     <= a_d;
               b_q     <= b_d;
               sum_q_s <= sum_d_s;
            end
         end

         assign stg_vld_s[k+1] = vld_q;
         assign stg_cin_s[k+1] = cin_q;
         assign stg_m_s[k+1]   = m_q;
         assign stg_a_s[k+1]   = a_q;
         assign stg_b_s[k+1]   = b_q;
         assign stg_sum_s[k+1] = sum_q_s;
      end else begin : g_last
         assign res_vld_s  = stg_vld_s[k];
         assign res_sum_s  = sum_next_s;
         assign res_co_s   = cout_s;
         assign res_cmsb_s = c_msb_s;
      end
   end

   // Output register next state: load a finished transaction unless stalled,
   // otherwise hold so the presented result stays stable.
   always_comb begin
      out_valid_d = out_valid_q;
      sum_d       = sum_q;
      flags_d     = flags_q;
      if (!stall_s) begin
         out_valid_d = res_vld_s;
         if (res_vld_s) begin
            sum_d   = res_sum_s;
            flags_d = make_flags(res_co_s, res_cmsb_s, res_sum_s[WIDTH-1],
                                 (res_sum_s == {WIDTH{1'b0}}));
         end else begin
            sum_d   = sum_q;
         end
      end else begin
         out_valid_d = out_valid_q;
      end
   end

   // Output stage register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         sum_q       <= {WIDTH{1'b0}};
         flags_q     <= add_sub_flags_t'(4'b0000);
      end else begin
         out_valid_q <= out_valid_d;
         sum_q       <= sum_d;
         flags_q     <= flags_d;
      end
   end

   assign out_valid = out_valid_q;
   assign Sum       = sum_q;
   assign Co        = flags_q.co;
   assign V         = flags_q.v;
   assign N         = flags_q.n;
   assign Z         = flags_q.z;

endmodule

// File: tb/tb_pipelined_add_sub.sv
// ---------------------------------------------------------------------------
// tb_pipelined_add_sub
//   Self-checking bench for pipelined_add_sub (WIDTH = 16, CHUNK = 4).
//   Inputs change on the falling edge; handshakes and outputs are sampled
//   1 time unit later, well clear of the rising edge. Accepted operands go
//   through an arithmetic reference model into an expected queue; delivered
//   results go into an observed queue; each test compares the two.
// ---------------------------------------------------------------------------
module tb_pipelined_add_sub;

   localparam int unsigned WIDTH   = 16;
   localparam int unsigned CHUNK   = 4;
   localparam int          LATENCY = 4;

   typedef struct {
      logic [15:0] sum;
      logic        co;
      logic        v;
      logic        n;
      logic        z;
      int          cyc;
   } res_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] A;
   logic [15:0] B;
   logic        M;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] Sum;
   logic        Co;
   logic        V;
   logic        N;
   logic        Z;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   res_t exp_q[$];
   res_t obs_q[$];

   logic [15:0] dir_a [4] = '{16'h7FFF, 16'h0005, 16'h1234, 16'hFFFF};
   logic [15:0] dir_b [4] = '{16'h0001, 16'h0007, 16'h1234, 16'h0001};
   logic        dir_m [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
   logic [15:0] dir_s [4] = '{16'h8000, 16'hFFFE, 16'h0000, 16'h0000};
   logic [3:0]  dir_f [4] = '{4'b0110, 4'b0010, 4'b1001, 4'b1001}; // {Co,V,N,Z}

   always #5 clk = ~clk;

   pipelined_add_sub #(
      .WIDTH (WIDTH),
      .CHUNK (CHUNK)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .M         (M),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .Sum       (Sum),
      .Co        (Co),
      .V         (V),
      .N         (N),
      .Z         (Z)
   );

   // Reference: exact integer arithmetic, then reduce modulo 2^16.
   function automatic res_t model(input logic [15:0] a, input logic [15:0] b,
                                  input logic m, input int c);
      res_t        r;
      int unsigned ua = a;
      int unsigned ub = b;
      int          sa = $signed(a);
      int          sb = $signed(b);
      int          exact;
      if (m == 1'b0) begin
         r.sum = 16'(ua + ub);
         r.co  = (ua + ub) > 32'd65535;
         exact = sa + sb;
      end else begin
         r.sum = 16'(ua - ub);
         r.co  = (ua >= ub);
         exact = sa - sb;
      end
      r.v   = (exact > 32767) || (exact < -32768);
      r.n   = r.sum[15];
      r.z   = (r.sum == 16'h0000);
      r.cyc = c;
      return r;
   endfunction

   task automatic step(input logic v, input logic [15:0] a, input logic [15:0] b,
                       input logic m, input logic ordy, output bit acc);
      res_t r;
      @(negedge clk);
      in_valid  = v;
      A         = a;
      B         = b;
      M         = m;
      out_ready = ordy;
      #1;
      cyc = cyc + 1;
      acc = in_valid && in_ready;
      if (acc) exp_q.push_back(model(a, b, m, cyc));
      if (out_valid && out_ready) begin
         r.sum = Sum; r.co = Co; r.v = V; r.n = N; r.z = Z; r.cyc = cyc;
         obs_q.push_back(r);
      end
   endtask

   task automatic drain(input int budget, input int want);
      bit acc;
      for (int j = 0; j < budget && obs_q.size() < want; j++)
         step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, acc);
   endtask

   task automatic clear_queues();
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; A = 16'h0000; B = 16'h0000; M = 1'b0; out_ready = 1'b0;
      #12;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      n_checks++; if (Sum !== 16'h0000) begin n_fail++; $display("FAIL reset_sum: got %h expected 0000", Sum); end
      n_checks++; if ({Co, V, N, Z} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags: got %b expected 0000", {Co, V, N, Z}); end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
   endtask

   task automatic test_directed();
      bit   acc;
      int   acc_cyc;
      res_t o;
      for (int i = 0; i < 4; i++) begin
         clear_queues();
         step(1'b1, dir_a[i], dir_b[i], dir_m[i], 1'b1, acc);
         acc_cyc = cyc;
         step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, acc);
         drain(20, 1);
         n_checks++;
         if (obs_q.size() != 1) begin
            n_fail++; $display("FAIL directed%0d_count: got %0d results expected 1", i, obs_q.size());
            continue;
         end
         o = obs_q[0];
         n_checks++; if (o.sum !== dir_s[i]) begin n_fail++; $display("FAIL directed%0d_sum: got %h expected %h", i, o.sum, dir_s[i]); end
         n_checks++; if ({o.co, o.v, o.n, o.z} !== dir_f[i]) begin n_fail++; $display("FAIL directed%0d_flags: got %b expected %b", i, {o.co, o.v, o.n, o.z}, dir_f[i]); end
         n_checks++; if (o.cyc - acc_cyc != LATENCY) begin n_fail++; $display("FAIL directed%0d_latency: got %0d expected %0d", i, o.cyc - acc_cyc, LATENCY); end
      end
   endtask

   task automatic test_back_to_back();
      bit   acc;
      res_t o;
      res_t e;
      clear_queues();
      for (int i = 0; i < 8; i++)
         step(1'b1, 16'($urandom), 16'($urandom), (i % 2 == 1), 1'b1, acc);
      drain(30, 8);
      n_checks++;
      if (obs_q.size() != 8 || exp_q.size() != 8) begin
         n_fail++; $display("FAIL b2b_count: got %0d/%0d expected 8/8", obs_q.size(), exp_q.size());
      end else begin
         for (int i = 0; i < 8; i++) begin
            o = obs_q[i]; e = exp_q[i];
            n_checks++; if ({o.sum, o.co, o.v, o.n, o.z} !== {e.sum, e.co, e.v, e.n, e.z}) begin
               n_fail++; $display("FAIL b2b_result%0d: got %h expected %h", i, {o.sum, o.co, o.v, o.n, o.z}, {e.sum, e.co, e.v, e.n, e.z}); end
            n_checks++; if (o.cyc != e.cyc + LATENCY) begin
               n_fail++; $display("FAIL b2b_timing%0d: got cycle %0d expected %0d", i, o.cyc, e.cyc + LATENCY); end
         end
      end
   endtask

   task automatic test_backpressure();
      logic [15:0] oa [12];
      logic [15:0] ob [12];
      logic        om [12];
      logic [19:0] held = 20'h00000;
      int          idx = 0;
      bit          acc;
      logic        ordy;
      res_t        o;
      res_t        e;
      clear_queues();
      for (int i = 0; i < 12; i++) begin
         oa[i] = 16'($urandom); ob[i] = 16'($urandom); om[i] = 1'($urandom);
      end
      for (int j = 1; j <= 80 && !(idx == 12 && obs_q.size() >= 12); j++) begin
         ordy = !(j >= 7 && j <= 11);
         if (idx < 12) step(1'b1, oa[idx], ob[idx], om[idx], ordy, acc);
         else          step(1'b0, 16'h0000, 16'h0000, 1'b0, ordy, acc);
         if (acc) idx++;
         if (j == 7) held = {Sum, Co, V, N, Z};
         if (!ordy) begin
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid@%0d: got %b expected 1", j, out_valid); end
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready@%0d: got %b expected 0", j, in_ready); end
            if (j > 7) begin
               n_checks++; if ({Sum, Co, V, N, Z} !== held) begin n_fail++; $display("FAIL bp_hold@%0d: got %h expected %h", j, {Sum, Co, V, N, Z}, held); end
            end
         end
      end
      n_checks++;
      if (obs_q.size() != 12 || exp_q.size() != 12) begin
         n_fail++; $display("FAIL bp_count: got %0d/%0d expected 12/12", obs_q.size(), exp_q.size());
      end else begin
         for (int i = 0; i < 12; i++) begin
            o = obs_q[i]; e = exp_q[i];
            n_checks++; if ({o.sum, o.co, o.v, o.n, o.z} !== {e.sum, e.co, e.v, e.n, e.z}) begin
               n_fail++; $display("FAIL bp_result%0d: got %h expected %h", i, {o.sum, o.co, o.v, o.n, o.z}, {e.sum, e.co, e.v, e.n, e.z}); end
         end
      end
   endtask

   task automatic test_random();
      logic [15:0] ca = 16'($urandom);
      logic [15:0] cb = 16'($urandom);
      logic        cm = 1'($urandom);
      logic        cv = 1'b1;
      logic        ordy;
      bit          acc;
      int          n;
      res_t        o;
      res_t        e;
      clear_queues();
      for (int j = 0; j < 200; j++) begin
         ordy = ($urandom_range(0, 3) != 0);
         step(cv, ca, cb, cm, ordy, acc);
         if (acc || !cv) begin
            cv = ($urandom_range(0, 9) < 7);
            ca = 16'($urandom); cb = 16'($urandom); cm = 1'($urandom);
         end
      end
      drain(40, exp_q.size());
      n = exp_q.size();
      n_checks++;
      if (obs_q.size() != n) begin
         n_fail++; $display("FAIL rand_count: got %0d expected %0d", obs_q.size(), n);
      end else begin
         for (int i = 0; i < n; i++) begin
            o = obs_q[i]; e = exp_q[i];
            n_checks++; if ({o.sum, o.co, o.v, o.n, o.z} !== {e.sum, e.co, e.v, e.n, e.z}) begin
               n_fail++; $display("FAIL rand_result%0d: got %h expected %h", i, {o.sum, o.co, o.v, o.n, o.z}, {e.sum, e.co, e.v, e.n, e.z}); end
         end
      end
   endtask

   task automatic test_reset_midstream();
      bit   acc;
      int   acc_cyc;
      res_t o;
      res_t e;
      clear_queues();
      for (int i = 0; i < 4; i++)
         step(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'b1, acc);
      step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, acc);
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid: got %b expected 1", out_valid); end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_valid: got %b expected 0", out_valid); end
      n_checks++; if ({Sum, Co, V, N, Z} !== 20'h00000) begin n_fail++; $display("FAIL mid_reset_outputs: got %h expected 00000", {Sum, Co, V, N, Z}); end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      clear_queues();
      for (int i = 0; i < 6; i++) step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, acc);
      n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL mid_stale: got %0d results expected 0", obs_q.size()); end
      step(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'b1, acc);
      acc_cyc = cyc;
      drain(20, 1);
      n_checks++;
      if (obs_q.size() != 1 || exp_q.size() != 1) begin
         n_fail++; $display("FAIL mid_after_count: got %0d/%0d expected 1/1", obs_q.size(), exp_q.size());
      end else begin
         o = obs_q[0]; e = exp_q[0];
         n_checks++; if ({o.sum, o.co, o.v, o.n, o.z} !== {e.sum, e.co, e.v, e.n, e.z}) begin
            n_fail++; $display("FAIL mid_after_result: got %h expected %h", {o.sum, o.co, o.v, o.n, o.z}, {e.sum, e.co, e.v, e.n, e.z}); end
         n_checks++; if (o.cyc - acc_cyc != LATENCY) begin
            n_fail++; $display("FAIL mid_after_latency: got %0d expected %0d", o.cyc - acc_cyc, LATENCY); end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_backpressure();
      test_random();
      test_reset_midstream();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
